// File: rtl/control_multicycle_32_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs,
// datapath mux selects and the packed control vector.
package control_multicycle_32_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_HALT     = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic [1:0] RD_RT      = 2'b00;
  localparam logic [1:0] RD_RD      = 2'b01;
  localparam logic [1:0] RD_R31     = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] BR_NONE    = 2'b00;
  localparam logic [1:0] BR_EQ      = 2'b01;
  localparam logic [1:0] BR_NE      = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_RS     = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_toreg;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] branch;
    logic [1:0] pc_source;
  } ctrl_t;

  // R-type functs that go through EXEC/R_WB; jr is routed separately.
  function automatic logic rtype_alu_funct(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

endpackage

// File: rtl/control_multicycle_32_out_decode.sv
// Combinational state -> Moore control vector. Mealy overrides and the
// beq/bne branch select are applied by the top.
module mc_out_decode
  import control_multicycle_32_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.i_or_d   = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_toreg = MTR_MDR;
        ctrl.reg_dst   = RD_RT;
      end
      S_MEM_WR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = RD_RD;
        ctrl.mem_toreg = MTR_ALUOUT;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_RT;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = RD_RT;
        ctrl.mem_toreg = MTR_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      S_JAL: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = RD_R31;
        ctrl.mem_toreg = MTR_PC;
      end
      S_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_RS;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_multicycle_32.sv
// Multicycle MIPS main controller: FSM sequencing, memory watchdog and error
// flags around the Moore control decoder.
module control_multicycle_32
  import control_multicycle_32_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 16,
  parameter bit TRAP_ON_ILLEGAL = 1'b0,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_toreg,
  output logic [1:0] reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] branch,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       err_illegal_opcode,
  output logic       err_mem_timeout
);

  localparam logic             WDOG_EN  = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d, decode_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_ill_q, err_ill_d;
  logic             err_to_q, err_to_d;
  logic             illegal, waiting, timeout_hit;
  ctrl_t            moore_ctrl, ctrl;

  mc_out_decode u_out_decode (
    .state (state_q),
    .ctrl  (moore_ctrl)
  );

  always_comb begin
    illegal     = 1'b0;
    decode_next = S_FETCH;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR)              decode_next = S_JR;
        else if (rtype_alu_funct(funct)) decode_next = S_EXEC;
        else                             illegal     = 1'b1;
      end
      OP_LW, OP_SW:   decode_next = S_MEM_ADDR;
      OP_BEQ, OP_BNE: decode_next = S_BRANCH;
      OP_ADDI:        decode_next = S_ADDI_EX;
      OP_J:           decode_next = S_JUMP;
      OP_JAL:         decode_next = S_JAL;
      default:        illegal     = 1'b1;
    endcase
    if (illegal) decode_next = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
  end

  always_comb begin
    state_d     = state_q;
    err_to_d    = err_to_q;
    waiting     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // mem_ready on the last allowed cycle beats the watchdog
    timeout_hit = WDOG_EN && waiting && !mem_ready && (cnt_q == CNT_LAST);
    // err_illegal_opcode only persists when the illegal instruction trapped into HALT
    err_ill_d   = ((state_q == S_DECODE) && illegal) || (err_ill_q && (state_q == S_HALT));
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE:   state_d = decode_next;
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC:     state_d = S_R_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
    if (timeout_hit) begin
      state_d  = S_HALT;
      err_to_d = 1'b1;
    end
    cnt_d = (waiting && !mem_ready && !timeout_hit) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_ill_q <= err_ill_d;
      err_to_q  <= err_to_d;
    end
  end

  always_comb begin
    ctrl = moore_ctrl;
    if (state_q == S_FETCH) begin
      ctrl.ir_write = mem_ready;
      ctrl.pc_write = mem_ready;
    end
    if (state_q == S_BRANCH) ctrl.branch = (opcode == OP_BNE) ? BR_NE : BR_EQ;
    else                     ctrl.branch = BR_NONE;
    // FETCH is the reset state but must not request memory while held in reset
    if (!rst_n) ctrl = '0;
  end

  assign pc_write           = ctrl.pc_write;
  assign pc_write_cond      = ctrl.pc_write_cond;
  assign i_or_d             = ctrl.i_or_d;
  assign ir_write           = ctrl.ir_write;
  assign mem_read           = ctrl.mem_read;
  assign mem_write          = ctrl.mem_write;
  assign mem_toreg          = ctrl.mem_toreg;
  assign reg_dst            = ctrl.reg_dst;
  assign reg_write          = ctrl.reg_write;
  assign alu_src_a          = ctrl.alu_src_a;
  assign alu_src_b          = ctrl.alu_src_b;
  assign alu_op             = ctrl.alu_op;
  assign branch             = ctrl.branch;
  assign pc_source          = ctrl.pc_source;
  assign state              = state_q;
  assign err_illegal_opcode = err_ill_q;
  assign err_mem_timeout    = err_to_q;

endmodule
